data_memory_responder: RTL and testbench
========================================

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width; memory depth SHALL be 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 16, word width; all data ports SHALL be DATA_W bits.
REQ-003 Clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Daddress  input  16  processor word address, read and write.
REQ-006 Dout  input  16  processor write data.
REQ-007 W  input  1  processor write strobe, level.
REQ-008 DataIn  output  16  registered read data to processor.
REQ-009 load_valid  input  1  loader word valid.
REQ-010 load_ready  output  1  loader may transfer, high only in LOAD.
REQ-011 load_addr  input  16  loader word address.
REQ-012 load_data  input  16  loader word.
REQ-013 load_done  input  1  loader request to end LOAD.
REQ-014 run  output  1  high while in RUN.
REQ-015 addr_err  output  1  sticky out-of-range flag.
REQ-016 wr_count  output  16  accepted processor writes, saturating.

Function
REQ-017 FSM states SHALL be LOAD and RUN only; reset enters LOAD.
REQ-018 LOAD: load_ready=1; a transfer occurs on any edge with load_valid=1, writing mem[load_addr] <= load_data.
REQ-019 LOAD -> RUN on the edge where load_done=1; a transfer on that same edge SHALL still be written.
REQ-020 RUN is terminal; only Reset returns to LOAD.
REQ-021 In LOAD: DataIn SHALL be held at 0, and W SHALL cause no write.
REQ-022 In RUN: DataIn SHALL be mem[Daddress] registered, 1-cycle latency.
REQ-023 Address in range iff bits [15:ADDR_W] are all zero; only bits [ADDR_W-1:0] index memory.
REQ-024 Out-of-range read in RUN: DataIn SHALL be 0 on the next edge.
REQ-025 Out-of-range write, processor or loader: the write SHALL be dropped and addr_err SHALL be set.
REQ-026 W_q SHALL register W on every edge, in both states.
REQ-027 Processor write SHALL occur only when: state RUN, W=1, W_q=0 (rising edge); then mem[Daddress] <= Dout.
REQ-028 W held high N cycles SHALL produce exactly one write.
REQ-029 W that rose during LOAD and stays high into RUN SHALL produce no write.
REQ-030 Write and read to the same address on one edge SHALL be write-first: DataIn gets Dout.
REQ-031 wr_count SHALL increment by 1 per in-range accepted processor write.
REQ-032 wr_count SHALL saturate at 16'hFFFF.
REQ-033 Dropped writes SHALL NOT increment wr_count.
REQ-034 addr_err SHALL remain set until Reset.

Reset
REQ-035 Reset low SHALL immediately clear: DataIn=0, wr_count=0, addr_err=0, W_q=0, state=LOAD, run=0.
REQ-036 load_ready SHALL be 1 while in LOAD, including during and directly after reset.
REQ-037 Memory contents SHALL NOT be cleared by Reset.
REQ-038 Reset during LOAD or RUN SHALL preserve all previously written words.

Verification
REQ-039 Load & read: load mem[3]=16'hABCD, pulse load_done, Daddress=3 in RUN -> DataIn=16'hABCD one cycle later; run=1.
REQ-040 Edge write: Daddress=5, Dout=16'h1234, W high 3 cycles -> mem[5]=16'h1234; wr_count=1.
REQ-041 Same-edge write/read: W rising, Daddress=7, Dout=16'h00FF -> DataIn=16'h00FF on the next edge.
REQ-042 Out of range: Daddress=16'h0100, W pulse -> no write, wr_count unchanged, addr_err=1, DataIn=0.
REQ-043 Boundaries: W high at LOAD->RUN transition -> no write. load_valid and load_done together -> word stored and run=1.
REQ-044 Reset mid-RUN, after mem[2]=16'h5555 -> outputs 0, load_ready=1; re-enter RUN, read addr 2 -> 16'h5555.

Source files
------------

// File: rtl/data_memory_responder.sv
// data_memory_responder
//
// Word-addressed data memory shared between a boot-time loader and a
// processor. After reset the block sits in LOAD: the loader streams words
// in, the processor read port is held at zero and processor writes are
// ignored. When the loader raises load_done, the block moves to RUN for
// good. In RUN the processor reads with one cycle of latency and writes on
// the rising edge of its level write strobe. A new reset returns the block
// to LOAD but keeps the memory contents.
//
// Ports
//   Clock       rising-edge clock for all state
//   Reset       asynchronous active-low reset
//   Daddress    processor word address (read and write)
//   Dout        processor write data
//   W           processor write strobe (level; a write fires on its rise)
//   DataIn      registered read data to the processor
//   load_valid  loader word valid
//   load_ready  loader may transfer (high only in LOAD)
//   load_addr   loader word address
//   load_data   loader word
//   load_done   loader request to leave LOAD
//   run         high while in RUN
//   addr_err    sticky flag: an out-of-range write was dropped
//   wr_count    accepted processor writes, saturating at all-ones

module data_memory_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [15:0]       Daddress,
  input  logic [DATA_W-1:0] Dout,
  input  logic              W,
  output logic [DATA_W-1:0] DataIn,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [15:0]       load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_done,
  output logic              run,
  output logic              addr_err,
  output logic [15:0]       wr_count
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // An address is usable only when every bit above the index field is zero;
  // aliasing high addresses onto low words would silently corrupt memory.
  function automatic logic addr_in_range(input logic [15:0] addr);
    addr_in_range = ((addr >> ADDR_W) == 16'd0);
  endfunction

  state_t              state_r;
  state_t              state_next_s;
  logic                w_q_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];

  logic                load_in_range_s;
  logic                proc_in_range_s;
  logic [ADDR_W-1:0]   load_idx_s;
  logic [ADDR_W-1:0]   proc_idx_s;
  logic                w_rise_s;
  logic                load_wr_s;
  logic                proc_wr_s;
  logic                err_set_s;
  logic [DATA_W-1:0]   rd_next_s;

  assign load_in_range_s = addr_in_range(load_addr);
  assign proc_in_range_s = addr_in_range(Daddress);
  assign load_idx_s      = load_addr[ADDR_W-1:0];
  assign proc_idx_s      = Daddress[ADDR_W-1:0];
  // Only the low-to-high transition of W requests a write, so a strobe held
  // for many cycles writes once.
  assign w_rise_s        = W & ~w_q_r;

  assign run        = (state_r == ST_RUN);
  assign load_ready = (state_r == ST_LOAD);

  // State register: LOAD after reset, RUN once the loader finishes.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state, write enables, error detection and next read value.
  always_comb begin
    state_next_s = state_r;
    load_wr_s    = 1'b0;
    proc_wr_s    = 1'b0;
    err_set_s    = 1'b0;
    rd_next_s    = {DATA_W{1'b0}};
    case (state_r)
      ST_LOAD: begin
        if (load_valid) begin
          if (load_in_range_s) begin
            load_wr_s = 1'b1;
          end else begin
            err_set_s = 1'b1;
          end
        end else begin
          load_wr_s = 1'b0;
        end
        // The transfer on the load_done edge is still written above.
        if (load_done) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_LOAD;
        end
      end
      ST_RUN: begin
        state_next_s = ST_RUN;
        if (w_rise_s) begin
          if (proc_in_range_s) begin
            proc_wr_s = 1'b1;
          end else begin
            err_set_s = 1'b1;
          end
        end else begin
          proc_wr_s = 1'b0;
        end
        // Write-first: a read of the word being written returns new data.
        if (!proc_in_range_s) begin
          rd_next_s = {DATA_W{1'b0}};
        end else if (proc_wr_s) begin
          rd_next_s = Dout;
        end else begin
          rd_next_s = mem_r[proc_idx_s];
        end
      end
      default: begin
        state_next_s = ST_LOAD;
      end
    endcase
  end

  // Memory array: deliberately outside reset so contents survive it.
  always_ff @(posedge Clock) begin
    if (load_wr_s) begin
      mem_r[load_idx_s] <= load_data;
    end else if (proc_wr_s) begin
      mem_r[proc_idx_s] <= Dout;
    end
  end

  // Write-strobe history, sampled in both states so a strobe raised in LOAD
  // is already seen as high when RUN starts.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      w_q_r <= 1'b0;
    end else begin
      w_q_r <= W;
    end
  end

  // Registered read data to the processor.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      DataIn <= {DATA_W{1'b0}};
    end else begin
      DataIn <= rd_next_s;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      addr_err <= 1'b0;
    end else if (err_set_s) begin
      addr_err <= 1'b1;
    end
  end

  // Saturating count of accepted processor writes.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_count <= 16'd0;
    end else if (proc_wr_s && (wr_count != 16'hFFFF)) begin
      wr_count <= wr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

  logic        Clock;
  logic        Reset;
  logic [15:0] Daddress;
  logic [15:0] Dout;
  logic        W;
  logic [15:0] DataIn;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_addr;
  logic [15:0] load_data;
  logic        load_done;
  logic        run;
  logic        addr_err;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;

  data_memory_responder dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Daddress   (Daddress),
    .Dout       (Dout),
    .W          (W),
    .DataIn     (DataIn),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_done  (load_done),
    .run        (run),
    .addr_err   (addr_err),
    .wr_count   (wr_count)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Reference model: memory as a plain array, behaviour from the rules.
  logic [15:0] m_mem [256];
  logic        m_run;
  logic        m_wq;
  logic        m_err;
  logic [15:0] m_cnt;
  logic [15:0] m_din;

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      m_run <= 1'b0;
      m_wq  <= 1'b0;
      m_err <= 1'b0;
      m_cnt <= 16'd0;
      m_din <= 16'd0;
    end else begin
      m_wq <= W;
      if (!m_run) begin
        m_din <= 16'd0;
        if (load_valid) begin
          if (load_addr < 16'd256) m_mem[load_addr[7:0]] <= load_data;
          else m_err <= 1'b1;
        end
        if (load_done) m_run <= 1'b1;
      end else begin
        if (W && !m_wq) begin
          if (Daddress < 16'd256) begin
            m_mem[Daddress[7:0]] <= Dout;
            if (m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
          end else begin
            m_err <= 1'b1;
          end
        end
        if (Daddress >= 16'd256) m_din <= 16'd0;
        else if (W && !m_wq) m_din <= Dout;
        else m_din <= m_mem[Daddress[7:0]];
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clock) begin
    if (check_en) begin
      chk("DataIn", DataIn, m_din);
      chk("run", {15'd0, run}, {15'd0, m_run});
      chk("load_ready", {15'd0, load_ready}, {15'd0, !m_run});
      chk("addr_err", {15'd0, addr_err}, {15'd0, m_err});
      chk("wr_count", wr_count, m_cnt);
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset = 1'b0; Daddress = 16'd0; Dout = 16'd0; W = 1'b0;
    load_valid = 1'b0; load_addr = 16'd0; load_data = 16'd0; load_done = 1'b0;
    tick(); tick();
    check_en = 1'b1;
    chk("rst_load_ready", {15'd0, load_ready}, 16'd1);
    chk("rst_run", {15'd0, run}, 16'd0);
    chk("rst_datain", DataIn, 16'd0);
    Reset = 1'b1;
    tick();

    // Fill every word; W toggles but must not write in LOAD.
    for (int i = 0; i < 256; i++) begin
      load_valid = 1'b1;
      load_addr  = i[15:0];
      load_data  = (i == 3) ? 16'hABCD : 16'($urandom);
      W          = 1'($urandom_range(0, 1));
      Daddress   = 16'($urandom);
      Dout       = 16'($urandom);
      tick();
      if ($urandom_range(0, 7) == 0) begin
        load_valid = 1'b0;
        tick();
      end
    end
    chk("load_datain_zero", DataIn, 16'd0);
    chk("load_no_count", wr_count, 16'd0);

    // Transfer together with load_done; W high across the transition.
    W = 1'b0; load_valid = 1'b0; tick();
    load_valid = 1'b1; load_addr = 16'd9; load_data = 16'hBEEF; load_done = 1'b1;
    W = 1'b1; Daddress = 16'd3;
    tick();
    load_valid = 1'b0; load_done = 1'b0;
    tick();
    chk("run_high", {15'd0, run}, 16'd1);
    chk("read_abcd", DataIn, 16'hABCD);
    chk("no_write_across_run", wr_count, 16'd0);
    W = 1'b0; Daddress = 16'd9;
    tick();
    chk("read_beef", DataIn, 16'hBEEF);

    // Level W held three cycles writes once.
    W = 1'b1; Daddress = 16'd5; Dout = 16'h1234;
    tick(); tick(); tick();
    W = 1'b0;
    chk("edge_write_count", wr_count, 16'd1);
    tick();
    chk("read_1234", DataIn, 16'h1234);

    // Write and read same address on one edge.
    W = 1'b1; Daddress = 16'd7; Dout = 16'h00FF;
    tick();
    chk("write_first", DataIn, 16'h00FF);
    W = 1'b0; tick();

    // Out-of-range write.
    W = 1'b1; Daddress = 16'h0100; Dout = 16'hDEAD;
    tick();
    chk("oor_err", {15'd0, addr_err}, 16'd1);
    chk("oor_count", wr_count, 16'd2);
    chk("oor_datain", DataIn, 16'd0);
    W = 1'b0; tick();

    // Randomised RUN traffic.
    for (int i = 0; i < 400; i++) begin
      W = 1'($urandom_range(0, 1));
      Dout = 16'($urandom);
      if ($urandom_range(0, 7) == 0) Daddress = 16'($urandom_range(256, 65535));
      else Daddress = 16'($urandom_range(0, 255));
      tick();
    end

    // Write 5555 to word 2 then reset mid-RUN.
    W = 1'b0; tick();
    W = 1'b1; Daddress = 16'd2; Dout = 16'h5555; tick();
    W = 1'b0; tick();
    Reset = 1'b0;
    #1;
    chk("mid_rst_datain", DataIn, 16'd0);
    chk("mid_rst_count", wr_count, 16'd0);
    chk("mid_rst_err", {15'd0, addr_err}, 16'd0);
    chk("mid_rst_run", {15'd0, run}, 16'd0);
    chk("mid_rst_ready", {15'd0, load_ready}, 16'd1);
    tick();
    Reset = 1'b1;
    tick();
    chk("post_rst_ready", {15'd0, load_ready}, 16'd1);

    // Random loader traffic avoiding word 2, some out of range.
    for (int i = 0; i < 60; i++) begin
      load_valid = 1'($urandom_range(0, 1));
      load_data  = 16'($urandom);
      if ($urandom_range(0, 5) == 0) load_addr = 16'($urandom_range(256, 65535));
      else begin
        load_addr = 16'($urandom_range(0, 255));
        if (load_addr == 16'd2) load_addr = 16'd3;
      end
      W = 1'($urandom_range(0, 1));
      tick();
    end
    load_valid = 1'b0; load_done = 1'b1; W = 1'b0;
    tick();
    load_done = 1'b0; Daddress = 16'd2;
    tick();
    chk("reset_keeps_mem", DataIn, 16'h5555);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
